// File: rtl/set_ctrl.sv
// Clock-setting controller: RUN/SET mode FSM, field select rotation, increment pulses
// with hold-to-repeat, blink enable and an idle timeout back to RUN.
module set_ctrl #(
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned HOLD_S    = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tick_1hz,
  input  logic       i_btn_mode,
  input  logic       i_btn_sel,
  input  logic       i_btn_inc,
  output logic [2:0] o_sel,
  output logic       o_set_mode,
  output logic       o_run_en,
  output logic       o_inc_pulse,
  output logic       o_blink
);

  typedef enum logic {StRun, StSet} state_e;

  state_e     r_state, w_state_d;
  logic [2:0] r_sel, w_sel_d;
  logic [7:0] r_idle, w_idle_d;
  logic [3:0] r_hold, w_hold_d;
  logic       r_blink, w_blink_d;
  logic       r_inc, w_inc_d;
  logic       r_prev_mode, r_prev_sel, r_prev_inc;

  logic w_mode_edge, w_sel_edge, w_inc_edge, w_hold_full, w_timeout;

  assign w_mode_edge = i_btn_mode & ~r_prev_mode;
  assign w_sel_edge  = i_btn_sel & ~r_prev_sel;
  assign w_inc_edge  = i_btn_inc & ~r_prev_inc;
  assign w_hold_full = (r_hold == 4'(HOLD_S));
  // Any button edge on the final tick cancels the timeout and is processed instead.
  assign w_timeout   = i_tick_1hz & (r_idle == 8'(TIMEOUT_S - 1)) &
                       ~w_sel_edge & ~w_inc_edge & ~i_btn_inc;

  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_idle_d  = r_idle;
    w_hold_d  = r_hold;
    w_blink_d = r_blink;
    w_inc_d   = 1'b0;
    case (r_state)
      StRun: begin
        w_sel_d   = 3'b001;
        w_idle_d  = '0;
        w_hold_d  = '0;
        w_blink_d = 1'b0;
        if (w_mode_edge) w_state_d = StSet;
      end
      StSet: begin
        if (w_mode_edge || w_timeout) begin
          w_state_d = StRun;
          w_sel_d   = 3'b001;
          w_idle_d  = '0;
          w_hold_d  = '0;
          w_blink_d = 1'b0;
        end else begin
          case (r_sel)
            3'b001:  w_sel_d = w_sel_edge ? 3'b010 : 3'b001;
            3'b010:  w_sel_d = w_sel_edge ? 3'b100 : 3'b010;
            3'b100:  w_sel_d = w_sel_edge ? 3'b001 : 3'b100;
            default: w_sel_d = 3'b001;
          endcase
          if (!i_btn_inc) begin
            w_hold_d = '0;
          end else if (i_tick_1hz && !w_hold_full) begin
            w_hold_d = r_hold + 4'd1;
          end
          if (w_sel_edge || w_inc_edge || i_btn_inc) begin
            w_idle_d = '0;
          end else if (i_tick_1hz) begin
            w_idle_d = r_idle + 8'd1;
          end
          if (i_tick_1hz) w_blink_d = ~r_blink;
          // A sel edge swallows a simultaneous inc edge.
          w_inc_d = (w_inc_edge & ~w_sel_edge) | (i_tick_1hz & i_btn_inc & w_hold_full);
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StRun;
      r_sel       <= 3'b001;
      r_idle      <= '0;
      r_hold      <= '0;
      r_blink     <= 1'b0;
      r_inc       <= 1'b0;
      r_prev_mode <= 1'b1;
      r_prev_sel  <= 1'b1;
      r_prev_inc  <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_sel       <= w_sel_d;
      r_idle      <= w_idle_d;
      r_hold      <= w_hold_d;
      r_blink     <= w_blink_d;
      r_inc       <= w_inc_d;
      r_prev_mode <= i_btn_mode;
      r_prev_sel  <= i_btn_sel;
      r_prev_inc  <= i_btn_inc;
    end
  end

  assign o_sel       = r_sel;
  assign o_set_mode  = (r_state == StSet);
  assign o_run_en    = ~o_set_mode;
  assign o_inc_pulse = r_inc;
  assign o_blink     = r_blink;

endmodule

// File: doc/set_ctrl.md
SET_CTRL -- requirements
Module: set_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_S, default 10: the number of idle tick_1hz pulses in SET after which the block returns to RUN; legal range 2..255.
REQ-002 The block SHALL have parameter HOLD_S, default 2: the number of tick_1hz pulses btn_inc must be held before auto-repeat starts; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 tick_1hz  input  1  one-clk-wide pulse, once per second.
REQ-006 btn_mode  input  1  debounced level, synchronous to clk; toggles RUN/SET.
REQ-007 btn_sel  input  1  debounced level; advances the selected field.
REQ-008 btn_inc  input  1  debounced level; increments the selected field.
REQ-009 sel  output  3  one-hot field select: 001 hours, 010 minutes, 100 seconds.
REQ-010 set_mode  output  1  high while in SET.
REQ-011 run_en  output  1  high while in RUN; enables timekeeping counters.
REQ-012 inc_pulse  output  1  one-clk pulse: increment the field selected by sel.
REQ-013 blink  output  1  display blink enable for the selected field.

Function
REQ-014 The block SHALL detect edges as edge = level & ~prev, with prev registered every clk for each button.
REQ-015 The block SHALL implement a two-state FSM, RUN and SET; set_mode = (state==SET) and run_en = ~set_mode.
REQ-016 In RUN: sel held at 001; inc_pulse=0; blink=0; btn_sel and btn_inc are ignored.
REQ-017 RUN, btn_mode edge -> SET on the next clk; on entry, sel=001, idle counter=0, hold counter=0, blink=0.
REQ-018 SET, btn_mode edge -> RUN on the next clk; sel=001, blink=0, inc_pulse=0.
REQ-019 SET, btn_sel edge -> sel rotates 001->010->100->001 on the next clk; any non-one-hot sel value SHALL be forced to 001.
REQ-020 SET, btn_inc edge -> inc_pulse=1 for exactly one clk, registered, with 1-clk latency from the edge cycle.
REQ-021 Auto-repeat: in SET, while btn_inc is high, the hold counter increments on tick_1hz (saturating at HOLD_S).
REQ-022 Auto-repeat: once the hold counter equals HOLD_S, each further tick_1hz while btn_inc is high SHALL produce one inc_pulse.
REQ-023 Auto-repeat: btn_inc low clears the hold counter.
REQ-024 Idle counter: in SET it increments on tick_1hz and clears on any button edge or while btn_inc is high.
REQ-025 Idle timeout: a tick_1hz arriving with the idle counter at TIMEOUT_S-1 -> RUN on the next clk.
REQ-026 blink SHALL toggle on each tick_1hz in SET and be 0 in RUN.
REQ-027 Simultaneous edges: btn_mode has priority, and sel/inc edges in that cycle are dropped; btn_sel plus btn_inc in the same cycle advances sel with no inc_pulse.
REQ-028 Simultaneous edge and tick: a button edge coinciding with the timeout tick SHALL cancel the timeout, and the edge is processed.
REQ-029 A tick_1hz coinciding with an inc edge SHALL produce a single inc_pulse.
REQ-030 inc_pulse SHALL never be high in RUN, nor in the cycle the FSM leaves SET.

Reset
REQ-031 While reset_n=0, the block SHALL hold state=RUN, sel=001, set_mode=0, run_en=1, inc_pulse=0, blink=0, and idle and hold counters=0, asynchronously.
REQ-032 While reset_n=0, the prev registers SHALL reset to 1, so that a button held through reset release yields no edge.
REQ-033 Reset asserted mid-SET SHALL abort to RUN immediately, and no inc_pulse is emitted.

Verification
REQ-034 Mode round trip: release reset, pulse btn_mode -> set_mode=1 next clk, sel=001; pulse btn_mode again -> run_en=1, sel=001.
REQ-035 Field rotation: in SET, apply 4 btn_sel edges -> sel 010, 100, 001, 010; inc edge -> one inc_pulse 1 clk later, sel unchanged.
REQ-036 Timeout: enter SET, no buttons, 10 ticks -> RUN after the 10th tick; with an inc edge after tick 9 -> still SET after tick 10, RUN after tick 19.
REQ-037 Auto-repeat: hold btn_inc across 5 ticks (HOLD_S=2) -> inc_pulse on the edge plus ticks 3, 4, 5 (4 total), and no timeout.
REQ-038 Priority: btn_mode, btn_sel and btn_inc edges in the same clk in SET -> RUN, sel=001, no inc_pulse; btn_inc held high through reset release -> no inc_pulse.
